// File: rtl/acq_seq_pkg.sv
// Shared types and limits for the acquisition sequencer.
package acq_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Why the sequencer went to DRAIN; selects the exit path and the exit pulse.
  typedef enum logic [1:0] {
    END_NORMAL  = 2'd0,
    END_ABORT   = 2'd1,
    END_TIMEOUT = 2'd2
  } end_t;

  localparam logic [15:0] MAX_PTS        = 16'd2048;
  localparam logic [7:0]  MAX_NOISE_BITS = 8'd24;

  function automatic logic cfg_ok(input logic [15:0] ptos,
                                  input logic [7:0]  noise,
                                  input logic [15:0] n_ciclos);
    return (ptos != 16'd0) && (ptos <= MAX_PTS) &&
           (noise <= MAX_NOISE_BITS) && (n_ciclos != 16'd0);
  endfunction

endpackage

// File: rtl/acq_seq_timer.sv
// Loadable down-counter with zero flag; shared by the ARM watchdog and the DRAIN hold.
module acq_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: latches a source configuration, waits for the first
// zero-cross, forwards samples for n_ciclos signal cycles, then drains.
// Optional macro ACQ_SEQ_TIMEOUT_EN adds an ARM-state watchdog.
//
// state | meaning
// IDLE  | waiting for start; invalid config sets err_cfg
// LOAD  | latch config into src_*, clear counters
// ARM   | source enabled, waiting for first zero-cross
// RUN   | forwarding samples, counting cycles
// DRAIN | source disabled for DRAIN_CYCLES clocks, samples dropped
// FIN   | done pulse
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int DRAIN_CYCLES   = 3       // must be at least 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_ptos_x_ciclo,
  input  logic [7:0]  cfg_noise,
  input  logic        cfg_sel_ruido,
  input  logic [15:0] cfg_n_ciclos,
  input  logic        src_data_valid,
  input  logic        src_zero_cross,
  output logic        src_enable,
  output logic [15:0] src_ptos_x_ciclo,
  output logic [7:0]  src_noise,
  output logic        src_sel_ruido,
  output logic        stream_valid,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        err_cfg,
  output logic        err_timeout,
  output logic [15:0] cycle_count,
  output logic [31:0] sample_count
);

  // One timer serves both waits, so it is sized for the longer one.
  localparam int TW = $clog2(((TIMEOUT_CYCLES > DRAIN_CYCLES) ?
                              TIMEOUT_CYCLES : DRAIN_CYCLES) + 1);

  state_t          state, next_state;
  end_t            reason, reason_nxt;
  logic [15:0]     n_ciclos;
  logic [15:0]     cyc_next;
  logic            fwd, cyc_inc, set_err, enter_drain, drain_exit;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]   tmr_value;

  assign cyc_next = cycle_count + 16'd1;
  assign busy     = (state != S_IDLE);

  acq_seq_timer #(.WIDTH(TW)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state and per-cycle control decode; abort always beats sample handling.
  always_comb begin
    next_state  = state;
    reason_nxt  = END_NORMAL;
    fwd         = 1'b0;
    cyc_inc     = 1'b0;
    set_err     = 1'b0;
    enter_drain = 1'b0;
    drain_exit  = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_value   = '0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_ok(cfg_ptos_x_ciclo, cfg_noise, cfg_n_ciclos)) next_state = S_LOAD;
          else                                                   set_err    = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          enter_drain = 1'b1;
          reason_nxt  = END_ABORT;
        end else begin
          next_state = S_ARM;
`ifdef ACQ_SEQ_TIMEOUT_EN
          tmr_load   = 1'b1;
          tmr_value  = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      S_ARM: begin
        if (abort) begin
          enter_drain = 1'b1;
          reason_nxt  = END_ABORT;
        end else if (src_data_valid && src_zero_cross) begin
          next_state = S_RUN;
          fwd        = 1'b1;
        end
`ifdef ACQ_SEQ_TIMEOUT_EN
        else if (tmr_zero) begin
          enter_drain = 1'b1;
          reason_nxt  = END_TIMEOUT;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      S_RUN: begin
        if (abort) begin
          enter_drain = 1'b1;
          reason_nxt  = END_ABORT;
        end else if (src_data_valid) begin
          if (src_zero_cross) begin
            cyc_inc = 1'b1;
            // The zero-cross closing the last cycle belongs to the next one; drop it.
            if (cyc_next == n_ciclos) enter_drain = 1'b1;
            else                      fwd         = 1'b1;
          end else begin
            fwd = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (tmr_zero) begin
          drain_exit = 1'b1;
          next_state = (reason == END_NORMAL) ? S_FIN : S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (enter_drain) begin
      next_state = S_DRAIN;
      tmr_load   = 1'b1;
      tmr_value  = TW'(DRAIN_CYCLES - 1);
    end
  end

  // Registered outputs, latched configuration and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_enable       <= 1'b0;
      stream_valid     <= 1'b0;
      done             <= 1'b0;
      aborted          <= 1'b0;
      err_cfg          <= 1'b0;
      src_ptos_x_ciclo <= '0;
      src_noise        <= '0;
      src_sel_ruido    <= 1'b0;
      n_ciclos         <= '0;
      cycle_count      <= '0;
      sample_count     <= '0;
      reason           <= END_NORMAL;
    end else begin
      src_enable   <= (next_state == S_ARM) || (next_state == S_RUN);
      stream_valid <= fwd;
      done         <= (next_state == S_FIN);
      aborted      <= drain_exit && (reason == END_ABORT);
      if (enter_drain) reason <= reason_nxt;
      if (state == S_LOAD) begin
        src_ptos_x_ciclo <= cfg_ptos_x_ciclo;
        src_noise        <= cfg_noise;
        src_sel_ruido    <= cfg_sel_ruido;
        n_ciclos         <= cfg_n_ciclos;
        cycle_count      <= '0;
        sample_count     <= '0;
        err_cfg          <= 1'b0;
      end else begin
        if (set_err) err_cfg <= 1'b1;
        if (cyc_inc) cycle_count <= cyc_next;
        if (fwd && (sample_count != '1)) sample_count <= sample_count + 32'd1;
      end
    end
  end

`ifdef ACQ_SEQ_TIMEOUT_EN
  // Watchdog pulse on leaving a DRAIN that was entered by timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_timeout <= 1'b0;
    else          err_timeout <= drain_exit && (reason == END_TIMEOUT);
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65536, ARM-state watchdog limit in clocks.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, clocks to discard after enable drop.
REQ-003 SHALL have ports, one per line:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-clock request to begin an acquisition.
- abort  in  1  one-clock request to stop the current acquisition.
- cfg_ptos_x_ciclo  in  16  points per signal cycle.
- cfg_noise  in  8  noise width in bits.
- cfg_sel_ruido  in  1  noise generator select.
- cfg_n_ciclos  in  16  signal cycles to acquire.
- src_data_valid  in  1  sample valid from the data source.
- src_zero_cross  in  1  cycle-start marker from the data source.
- src_enable  out  1  data source enable.
- src_ptos_x_ciclo  out  16  latched points per cycle.
- src_noise  out  8  latched noise width.
- src_sel_ruido  out  1  latched generator select.
- stream_valid  out  1  gated sample valid for downstream.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-clock completion pulse.
- aborted  out  1  one-clock abort pulse.
- err_cfg  out  1  sticky configuration error.
- err_timeout  out  1  one-clock watchdog pulse.
- cycle_count  out  16  completed cycles.
- sample_count  out  32  forwarded samples, saturating.

Function
REQ-004 SHALL implement states IDLE, LOAD, ARM, RUN, DRAIN, FIN.
REQ-005 IDLE: start with valid config -> LOAD; start with invalid config -> set err_cfg, stay IDLE.
REQ-006 Config valid iff 1 <= cfg_ptos_x_ciclo <= 2048, cfg_noise <= 24, and cfg_n_ciclos >= 1.
REQ-007 LOAD (one clock): latch cfg_* into src_*; clear counters and err_cfg; -> ARM.
REQ-008 src_* SHALL hold their values from LOAD until the next LOAD.
REQ-009 src_enable SHALL be 1 in ARM and RUN only, registered, 0 otherwise.
REQ-010 ARM: on src_data_valid & src_zero_cross -> RUN; that sample SHALL be forwarded (stream_valid=1, sample_count=1).
REQ-011 RUN: stream_valid = src_data_valid, registered alongside a sample_count increment.
REQ-012 RUN, src_data_valid & src_zero_cross: cycle_count+1; if the new value equals n_ciclos -> DRAIN and that sample SHALL NOT be forwarded.
REQ-013 DRAIN: hold src_enable=0 for DRAIN_CYCLES clocks; stream_valid=0 regardless of src_data_valid; then -> FIN (normal) or IDLE (abort/timeout).
REQ-014 FIN: done=1 for one clock -> IDLE.
REQ-015 abort in LOAD/ARM/RUN: -> DRAIN at the next clock; aborted pulses on DRAIN exit; counters frozen.
REQ-016 abort in IDLE/DRAIN/FIN SHALL be ignored; start while busy SHALL be ignored; start and abort together in IDLE: abort wins (no-op).
REQ-017 sample_count SHALL saturate at 2^32-1; cycle_count cannot exceed n_ciclos.
REQ-018 Output latency: stream_valid lags src_data_valid by exactly 1 clock.

Reset
REQ-019 reset_n low SHALL force IDLE and all outputs 0 (src_ptos_x_ciclo=0, src_noise=0), mid-operation included, with no done/aborted pulse.

Configuration
REQ-020 With macro ACQ_SEQ_TIMEOUT_EN defined: TIMEOUT_CYCLES clocks in ARM without a zero-cross -> DRAIN, err_timeout pulses on DRAIN exit, no done.
REQ-021 Without ACQ_SEQ_TIMEOUT_EN: ARM waits indefinitely; err_timeout is tied to 0; no watchdog logic.

Structure
REQ-022 Package acq_seq_pkg SHALL hold the state enum, MAX_PTS=2048, and MAX_NOISE_BITS=24.
REQ-023 The watchdog/drain down-counter SHALL be sub-module acq_seq_timer (load, decrement, zero flag), instantiated once.

Verification
REQ-024 Config ptos=64, noise=8, sel=0, n=3; zero-cross every 64 valids -> cycle_count=3, sample_count=192, one done pulse.
REQ-025 ptos=0 or noise=25 or n=0 with start -> err_cfg=1, busy stays 0, src_enable never asserts.
REQ-026 abort 10 clocks into RUN -> src_enable 0 next clock, stream_valid 0 through DRAIN, aborted pulse after 3 clocks, no done.
REQ-027 Valid samples in DRAIN (3 stragglers) -> no stream_valid, sample_count unchanged.
REQ-028 ACQ_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=100, no zero-cross -> err_timeout pulse at ~100+3 clocks, return to IDLE.
REQ-029 reset_n low mid-RUN with cycle_count=2 -> all outputs 0 immediately; subsequent start runs normally from zero.
